ram_sp_be_init: RTL and testbench

Parametrised single-port synchronous RAM with column (byte) write enables. It has a built-in clear engine that sweeps every word to a fixed value after reset or on request. Read latency is selectable, with an optional output register, and a read-valid strobe marks returned data. It is the generic successor to the fixed-size single-port buffers in the encoder memory subsystem (reference-line, CABAC context and coefficient buffers).

---
 rtl/ram_sp_be_init.sv | 116 +++++++++++
 tb/tb_ram_sp_be_init.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_be_init.sv
// Single-port RAM with per-column write enables, a clear sweep engine
// and a 1- or 2-cycle read path with a read-valid strobe.
module ram_sp_be_init #(
   parameter int ADR_WD = 8,
   parameter int DEPTH = 240,
   parameter int DAT_WD = 32,
   parameter int COL_WD = 8,
   parameter int OUT_REG = 0,
   parameter logic [DAT_WD-1:0] INIT_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   output logic                     busy_o,
   input  logic [ADR_WD-1:0]        adr_i,
   input  logic                     wr_ena_i,
   input  logic [DAT_WD/COL_WD-1:0] wr_be_i,
   input  logic [DAT_WD-1:0]        wr_dat_i,
   input  logic                     rd_ena_i,
   output logic [DAT_WD-1:0]        rd_dat_o,
   output logic                     rd_val_o,
   output logic                     err_o
);

   localparam int NCOL = DAT_WD / COL_WD;
   localparam logic [ADR_WD:0] DEP_W = (ADR_WD+1)'(DEPTH);
   localparam logic [ADR_WD-1:0] LAST = ADR_WD'(DEPTH - 1);

   typedef enum logic {ST_CLR, ST_IDLE} state_t;

   state_t state_q, state_d;
   logic [ADR_WD-1:0] cnt_q, cnt_d;
   logic busy_q, busy_d;
   logic err_q, err_d;
   logic s1_val_q, s1_val_d;
   logic [DAT_WD-1:0] s1_dat_q, s1_dat_d;
   logic o_val_q, o_val_d;
   logic [DAT_WD-1:0] o_dat_q, o_dat_d;

   logic idle, in_rng, acc, wr_go, rd_go, mem_we;
   logic [ADR_WD-1:0] mem_adr;
   logic [NCOL-1:0] mem_be;
   logic [DAT_WD-1:0] mem_wdat;
   logic [DAT_WD-1:0] mem_q [DEPTH];

   always_comb begin
      idle = (state_q == ST_IDLE);
      in_rng = ({1'b0, adr_i} < DEP_W);
      acc = wr_ena_i | rd_ena_i;
      // a clear request takes priority over any access in the same cycle
      wr_go = idle & ~clr_i & wr_ena_i & in_rng;
      rd_go = idle & ~clr_i & rd_ena_i & ~wr_ena_i & in_rng;

      state_d = state_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (clr_i) begin
         state_d = ST_CLR;
         cnt_d = '0;
         err_d = 1'b0;
      end else if (!idle) begin
         cnt_d = cnt_q + ADR_WD'(1);
         if (cnt_q == LAST) state_d = ST_IDLE;
      end else if (acc & (~in_rng | (wr_ena_i & rd_ena_i))) begin
         err_d = 1'b1;
      end
      busy_d = (state_d == ST_CLR);

      mem_we = rst_n & (~idle | wr_go);
      mem_adr = idle ? adr_i : cnt_q;
      mem_be = idle ? wr_be_i : '1;
      mem_wdat = idle ? wr_dat_i : INIT_VAL;

      s1_val_d = rd_go;
      s1_dat_d = rd_go ? mem_q[adr_i] : s1_dat_q;
      o_val_d = s1_val_q;
      o_dat_d = s1_val_q ? s1_dat_q : o_dat_q;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < NCOL; k++) begin
            if (mem_be[k])
               mem_q[mem_adr][k*COL_WD +: COL_WD] <= mem_wdat[k*COL_WD +: COL_WD];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_CLR;
         cnt_q <= '0;
         busy_q <= 1'b1;
         err_q <= 1'b0;
         s1_val_q <= 1'b0;
         s1_dat_q <= '0;
         o_val_q <= 1'b0;
         o_dat_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         busy_q <= busy_d;
         err_q <= err_d;
         s1_val_q <= s1_val_d;
         s1_dat_q <= s1_dat_d;
         o_val_q <= o_val_d;
         o_dat_q <= o_dat_d;
      end
   end

   assign busy_o = busy_q;
   assign err_o = err_q;
   assign rd_val_o = (OUT_REG != 0) ? o_val_q : s1_val_q;
   assign rd_dat_o = (OUT_REG != 0) ? o_dat_q : s1_dat_q;

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Bench for ram_sp_be_init: two instances (1-cycle/INIT 0 and
// 2-cycle/INIT all-ones) driven together against a behavioural model.
module tb_ram_sp_be_init;

   localparam int DEPTH = 240;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, clr_i, wr_ena_i, rd_ena_i;
   logic [7:0] adr_i;
   logic [3:0] wr_be_i;
   logic [31:0] wr_dat_i;
   logic busy0, busy1, val0, val1, err0, err1;
   logic [31:0] dat0, dat1;

   ram_sp_be_init #(.OUT_REG(0), .INIT_VAL(32'h0000_0000)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .busy_o(busy0),
      .adr_i(adr_i), .wr_ena_i(wr_ena_i), .wr_be_i(wr_be_i),
      .wr_dat_i(wr_dat_i), .rd_ena_i(rd_ena_i), .rd_dat_o(dat0),
      .rd_val_o(val0), .err_o(err0)
   );

   ram_sp_be_init #(.OUT_REG(1), .INIT_VAL(32'hFFFF_FFFF)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .busy_o(busy1),
      .adr_i(adr_i), .wr_ena_i(wr_ena_i), .wr_be_i(wr_be_i),
      .wr_dat_i(wr_dat_i), .rd_ena_i(rd_ena_i), .rd_dat_o(dat1),
      .rd_val_o(val1), .err_o(err1)
   );

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;

   // reference state per instance
   logic [31:0] mm [2][DEPTH];
   int bl [2];
   bit em [2];
   logic [31:0] dm [2];
   bit pv [2][4];
   logic [31:0] pd [2][4];
   int lat [2];
   logic [31:0] ini [2];

   int nv [2];
   int logc [2][8];
   logic [31:0] logd [2][8];
   logic [31:0] lastd [2];
   bit sweep_chk = 1'b0;
   int sweep_bad [2];

   typedef struct {
      bit wr;
      bit rd;
      logic [7:0] adr;
      logic [3:0] be;
      logic [31:0] dat;
      logic [31:0] e0;
      logic [31:0] e1;
      bit ee;
   } vec_t;

   vec_t tv [17];

   function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endfunction

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            bl[i] = DEPTH;
            em[i] = 1'b0;
            dm[i] = '0;
            for (int s = 0; s < 4; s++) pv[i][s] = 1'b0;
            for (int a = 0; a < DEPTH; a++) mm[i][a] = ini[i];
         end else if (bl[i] > 0) begin
            if (clr_i) begin
               bl[i] = DEPTH;
               em[i] = 1'b0;
            end else begin
               bl[i]--;
            end
         end else if (clr_i) begin
            bl[i] = DEPTH;
            em[i] = 1'b0;
            for (int a = 0; a < DEPTH; a++) mm[i][a] = ini[i];
         end else if ((wr_ena_i || rd_ena_i) && int'(adr_i) >= DEPTH) begin
            em[i] = 1'b1;
         end else if (wr_ena_i) begin
            for (int k = 0; k < 4; k++)
               if (wr_be_i[k]) mm[i][adr_i][8*k +: 8] = wr_dat_i[8*k +: 8];
            if (rd_ena_i) em[i] = 1'b1;
         end else if (rd_ena_i) begin
            pv[i][(cyc + lat[i]) % 4] = 1'b1;
            pd[i][(cyc + lat[i]) % 4] = mm[i][adr_i];
         end
      end
   endtask

   task automatic step();
      logic ab [2];
      logic av [2];
      logic ae [2];
      logic [31:0] ad [2];
      bit ev;
      model_edge();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      ab[0] = busy0; ab[1] = busy1;
      av[0] = val0;  av[1] = val1;
      ae[0] = err0;  ae[1] = err1;
      ad[0] = dat0;  ad[1] = dat1;
      for (int i = 0; i < 2; i++) begin
         ev = pv[i][cyc % 4];
         if (ev) begin
            dm[i] = pd[i][cyc % 4];
            pv[i][cyc % 4] = 1'b0;
         end
         chk($sformatf("busy%0d c%0d", i, cyc), 32'(ab[i]), 32'(bl[i] > 0));
         chk($sformatf("rd_val%0d c%0d", i, cyc), 32'(av[i]), 32'(ev));
         chk($sformatf("rd_dat%0d c%0d", i, cyc), ad[i], dm[i]);
         chk($sformatf("err%0d c%0d", i, cyc), 32'(ae[i]), 32'(em[i]));
         if (av[i] === 1'b1) begin
            if (nv[i] < 8) begin
               logc[i][nv[i]] = cyc;
               logd[i][nv[i]] = ad[i];
            end
            nv[i]++;
            lastd[i] = ad[i];
            if (sweep_chk && ad[i] !== ini[i]) sweep_bad[i]++;
         end
      end
      wr_ena_i = 1'b0;
      rd_ena_i = 1'b0;
      clr_i = 1'b0;
   endtask

   task automatic count_busy(output int n, output int nval, input bit noise);
      int v;
      n = 0;
      v = nv[0] + nv[1];
      while (busy0 === 1'b1 && n < 2000) begin
         n++;
         if (noise) begin
            wr_ena_i = 1'($urandom_range(0, 1));
            rd_ena_i = 1'($urandom_range(0, 1));
            adr_i = 8'($urandom_range(0, 255));
            wr_be_i = 4'($urandom);
            wr_dat_i = 32'($urandom);
         end
         step();
      end
      nval = nv[0] + nv[1] - v;
   endtask

   initial begin
      int n, nval, n0;
      int r;

      lat[0] = 1; lat[1] = 2;
      ini[0] = 32'h0000_0000; ini[1] = 32'hFFFF_FFFF;
      sweep_bad[0] = 0; sweep_bad[1] = 0;
      nv[0] = 0; nv[1] = 0;

      tv[0]  = '{1'b0, 1'b1, 8'd0,   4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
      tv[1]  = '{1'b0, 1'b1, 8'd120, 4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
      tv[2]  = '{1'b0, 1'b1, 8'd239, 4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
      tv[3]  = '{1'b1, 1'b0, 8'd5,   4'hF, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0};
      tv[4]  = '{1'b1, 1'b0, 8'd5,   4'h5, 32'h1122_3344, 32'h0,         32'h0,         1'b0};
      tv[5]  = '{1'b0, 1'b1, 8'd5,   4'h0, 32'h0,         32'hDE22_BE44, 32'hDE22_BE44, 1'b0};
      tv[6]  = '{1'b1, 1'b0, 8'd9,   4'h2, 32'h0000_AB00, 32'h0,         32'h0,         1'b0};
      tv[7]  = '{1'b0, 1'b1, 8'd9,   4'h0, 32'h0,         32'h0000_AB00, 32'hFFFF_ABFF, 1'b0};
      tv[8]  = '{1'b1, 1'b0, 8'd10,  4'h0, 32'h1234_5678, 32'h0,         32'h0,         1'b0};
      tv[9]  = '{1'b0, 1'b1, 8'd10,  4'h0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
      tv[10] = '{1'b1, 1'b0, 8'd1,   4'hF, 32'h0000_00A1, 32'h0,         32'h0,         1'b0};
      tv[11] = '{1'b1, 1'b0, 8'd2,   4'hF, 32'h0000_00A2, 32'h0,         32'h0,         1'b0};
      tv[12] = '{1'b1, 1'b0, 8'd3,   4'hF, 32'h0000_00A3, 32'h0,         32'h0,         1'b0};
      tv[13] = '{1'b1, 1'b0, 8'd240, 4'hF, 32'h0000_0099, 32'h0,         32'h0,         1'b1};
      tv[14] = '{1'b0, 1'b1, 8'd5,   4'h0, 32'h0,         32'hDE22_BE44, 32'hDE22_BE44, 1'b1};
      tv[15] = '{1'b1, 1'b1, 8'd7,   4'hF, 32'h0000_0055, 32'h0,         32'h0,         1'b1};
      tv[16] = '{1'b0, 1'b1, 8'd7,   4'h0, 32'h0,         32'h0000_0055, 32'h0000_0055, 1'b1};

      rst_n = 1'b0; clr_i = 1'b0; wr_ena_i = 1'b0; rd_ena_i = 1'b0;
      adr_i = '0; wr_be_i = '0; wr_dat_i = '0;
      @(negedge clk);
      step();
      step();
      chk("reset busy", 32'(busy0), 32'd1);
      chk("reset rd_val", 32'(val1), 32'd0);
      chk("reset rd_dat", dat0, 32'h0);
      chk("reset err", 32'(err1), 32'd0);

      rst_n = 1'b1;
      count_busy(n, nval, 1'b0);
      chk("init sweep length", n, 240);

      for (int v = 0; v < 17; v++) begin
         wr_ena_i = tv[v].wr;
         rd_ena_i = tv[v].rd;
         adr_i = tv[v].adr;
         wr_be_i = tv[v].be;
         wr_dat_i = tv[v].dat;
         nv[0] = 0; nv[1] = 0;
         step(); step(); step();
         chk($sformatf("vec%0d err", v), 32'(err0), 32'(tv[v].ee));
         if (tv[v].rd && !tv[v].wr) begin
            chk($sformatf("vec%0d nval", v), nv[0] + nv[1], 2);
            chk($sformatf("vec%0d dat0", v), lastd[0], tv[v].e0);
            chk($sformatf("vec%0d dat1", v), lastd[1], tv[v].e1);
         end else begin
            chk($sformatf("vec%0d nval", v), nv[0] + nv[1], 0);
         end
      end

      // back-to-back reads of adr 1..3
      nv[0] = 0; nv[1] = 0;
      n0 = cyc;
      for (int a = 1; a <= 3; a++) begin
         rd_ena_i = 1'b1;
         adr_i = 8'(a);
         step();
      end
      step(); step();
      chk("b2b count1", nv[1], 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("b2b cyc1_%0d", k), logc[1][k], n0 + 2 + k);
         chk($sformatf("b2b dat1_%0d", k), logd[1][k], 32'hA1 + 32'(k));
         chk($sformatf("b2b cyc0_%0d", k), logc[0][k], n0 + 1 + k);
      end

      clr_i = 1'b1;
      step();
      chk("clr err", 32'(err0), 32'd0);
      count_busy(n, nval, 1'b0);
      chk("clr sweep length", n, 240);

      // restart the sweep mid-way and hammer it with requests
      clr_i = 1'b1;
      step();
      repeat (99) step();
      clr_i = 1'b1;
      step();
      count_busy(n, nval, 1'b1);
      chk("restart sweep length", n, 240);
      chk("busy rd_val count", nval, 0);

      sweep_chk = 1'b1;
      nv[0] = 0; nv[1] = 0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_ena_i = 1'b1;
         adr_i = 8'(a);
         step();
      end
      step(); step();
      sweep_chk = 1'b0;
      chk("readback count0", nv[0], DEPTH);
      chk("readback count1", nv[1], DEPTH);
      chk("readback bad0", sweep_bad[0], 0);
      chk("readback bad1", sweep_bad[1], 0);

      // reset one cycle after a read
      rd_ena_i = 1'b1;
      adr_i = 8'd3;
      step();
      rst_n = 1'b0;
      step();
      chk("midrst rd_val1", 32'(val1), 32'd0);
      chk("midrst rd_dat1", dat1, 32'h0);
      chk("midrst rd_dat0", dat0, 32'h0);
      rst_n = 1'b1;
      count_busy(n, nval, 1'b0);
      chk("midrst sweep length", n, 240);
      chk("midrst rd_val count", nval, 0);

      for (int t = 0; t < 600; t++) begin
         r = $urandom_range(0, 199);
         wr_ena_i = (r < 70);
         rd_ena_i = (r >= 50 && r < 150);
         clr_i = (r == 199);
         if ($urandom_range(0, 19) == 0)
            adr_i = 8'($urandom_range(240, 255));
         else
            adr_i = 8'($urandom_range(0, 15));
         wr_be_i = 4'($urandom);
         wr_dat_i = 32'($urandom);
         step();
      end
      step(); step();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
